// File: rtl/lvds_tx_framer.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : lvds_tx_framer
// Description : Transmit-side link layer for the LVDS SerDes. Buffers payload
//               words in a FIFO, sequences lock-wait / training / align-ack /
//               sync, then serialises words MSB-beat-first onto tx_in, with
//               idle-word fill and periodic re-sync beats.
// Revision    : 1.0 - initial release
// ============================================================================
module lvds_tx_framer #(
  parameter int                 BEAT_W        = 8,
  parameter int                 WORD_W        = 32,
  parameter int                 FIFO_DEPTH    = 8,
  parameter int                 CNT_W         = 3,
  parameter logic [BEAT_W-1:0]  TRAIN_PAT     = BEAT_W'(8'h6A),
  parameter logic [BEAT_W-1:0]  ACK_PAT       = BEAT_W'(8'hA5),
  parameter logic [BEAT_W-1:0]  SYNC_PAT      = BEAT_W'(8'h77),
  parameter logic [WORD_W-1:0]  IDLE_WORD     = WORD_W'(32'h5252_5252),
  parameter int                 SYNC_INTERVAL = 64
) (
  input  logic              tx_inclock,
  input  logic              pll_areset,
  input  logic              tx_locked,
  input  logic              tx_align_done,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [BEAT_W-1:0] tx_in,
  output logic              link_up,
  output logic [CNT_W:0]    fifo_count,
  output logic              word_sent,
  output logic              sync_sent
);

  // Beats per word and counter widths derived from the parameters.
  localparam int                 c_BEATS     = WORD_W / BEAT_W;
  localparam int                 c_BCNT_W    = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
  localparam int                 c_WCNT_W    = (SYNC_INTERVAL > 1) ? $clog2(SYNC_INTERVAL + 1) : 1;
  localparam logic [c_BCNT_W-1:0] c_LAST_BEAT = c_BCNT_W'(c_BEATS - 1);
  localparam logic [c_WCNT_W-1:0] c_SYNC_CNT  = c_WCNT_W'(SYNC_INTERVAL);
  localparam logic [CNT_W:0]     c_FULL      = FIFO_DEPTH[CNT_W:0];
  localparam bit                 c_RESYNC_EN = (SYNC_INTERVAL != 0);

  typedef enum logic [2:0] {
    ST_LOCK_WAIT = 3'd0,
    ST_TRAIN     = 3'd1,
    ST_ACK       = 3'd2,
    ST_SYNC      = 3'd3,
    ST_DATA      = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // --------------------------------------------------------------------------
  logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
  logic [CNT_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_rd_ptr;
  logic [CNT_W:0]    r_count;
  logic              w_full;
  logic              w_empty;
  logic              w_enq;
  logic              w_deq;

  assign w_full     = (r_count == c_FULL);
  assign w_empty    = (r_count == '0);
  // Nothing is accepted while the PLL is unlocked, so a flush never races an enqueue.
  assign s_ready    = tx_locked & ~w_full;
  assign w_enq      = s_valid & s_ready;
  assign fifo_count = r_count;

  // Payload storage; contents need no reset because occupancy is tracked separately.
  always_ff @(posedge tx_inclock) begin
    if (w_enq) begin
      r_mem[r_wr_ptr] <= s_data;
    end
  end

  // Pointer and occupancy tracking; lock loss flushes everything queued.
  always_ff @(posedge tx_inclock or posedge pll_areset) begin
    if (pll_areset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (!tx_locked) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Link sequencing and serialisation
  // --------------------------------------------------------------------------
  state_t              r_state;
  state_t              w_state_nxt;
  logic [BEAT_W-1:0]   r_tx_in;
  logic [BEAT_W-1:0]   w_tx_nxt;
  logic                r_link_up;
  logic                w_link_nxt;
  logic                r_word_sent;
  logic                w_word_sent_nxt;
  logic                r_sync_sent;
  logic                w_sync_sent_nxt;
  logic [c_BCNT_W-1:0] r_beat;
  logic [c_BCNT_W-1:0] w_beat_nxt;
  logic [WORD_W-1:0]   r_shift;
  logic [WORD_W-1:0]   w_shift_nxt;
  logic [c_WCNT_W-1:0] r_wcnt;
  logic [c_WCNT_W-1:0] w_wcnt_nxt;
  logic [WORD_W-1:0]   w_word;
  logic                w_resync_due;

  assign w_resync_due = c_RESYNC_EN && (r_wcnt == c_SYNC_CNT);

  assign tx_in     = r_tx_in;
  assign link_up   = r_link_up;
  assign word_sent = r_word_sent;
  assign sync_sent = r_sync_sent;

  // Next state and next registered outputs. r_beat is the index of the beat
  // to drive on the coming edge; zero means a word boundary.
  always_comb begin
    w_state_nxt     = r_state;
    w_tx_nxt        = '0;
    w_word_sent_nxt = 1'b0;
    w_sync_sent_nxt = 1'b0;
    w_beat_nxt      = r_beat;
    w_shift_nxt     = r_shift;
    w_wcnt_nxt      = r_wcnt;
    w_word          = IDLE_WORD;
    w_deq           = 1'b0;

    if (!tx_locked) begin
      // Lock loss abandons any word in flight and restarts the bring-up sequence.
      w_state_nxt = ST_LOCK_WAIT;
      w_beat_nxt  = '0;
      w_shift_nxt = '0;
      w_wcnt_nxt  = '0;
    end else begin
      case (r_state)
        ST_LOCK_WAIT: begin
          w_state_nxt = ST_TRAIN;
          w_tx_nxt    = TRAIN_PAT;
        end
        ST_TRAIN: begin
          if (tx_align_done) begin
            w_state_nxt = ST_ACK;
            w_tx_nxt    = ACK_PAT;
          end else begin
            w_tx_nxt    = TRAIN_PAT;
          end
        end
        ST_ACK: begin
          w_state_nxt     = ST_SYNC;
          w_tx_nxt        = SYNC_PAT;
          w_sync_sent_nxt = 1'b1;
          w_wcnt_nxt      = '0;
          w_beat_nxt      = '0;
        end
        ST_SYNC, ST_DATA: begin
          w_state_nxt = ST_DATA;
          if (r_beat != '0) begin
            // Mid-word: shift out the next most-significant beat.
            w_tx_nxt    = r_shift[WORD_W-1 -: BEAT_W];
            w_shift_nxt = r_shift << BEAT_W;
            w_beat_nxt  = (r_beat == c_LAST_BEAT) ? '0 : r_beat + 1'b1;
          end else if (w_resync_due) begin
            // A re-sync beat takes the place of a word start.
            w_tx_nxt        = SYNC_PAT;
            w_sync_sent_nxt = 1'b1;
            w_wcnt_nxt      = '0;
          end else begin
            // Boundary: start the FIFO head, or idle fill when nothing is queued.
            w_word          = w_empty ? IDLE_WORD : r_mem[r_rd_ptr];
            w_deq           = ~w_empty;
            w_word_sent_nxt = ~w_empty;
            w_tx_nxt        = w_word[WORD_W-1 -: BEAT_W];
            w_shift_nxt     = w_word << BEAT_W;
            w_beat_nxt      = c_BCNT_W'(1);
            if (c_RESYNC_EN) begin
              w_wcnt_nxt = r_wcnt + 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = ST_LOCK_WAIT;
        end
      endcase
    end

    w_link_nxt = (w_state_nxt == ST_DATA);
  end

  // State and output registers.
  always_ff @(posedge tx_inclock or posedge pll_areset) begin
    if (pll_areset) begin
      r_state     <= ST_LOCK_WAIT;
      r_tx_in     <= '0;
      r_link_up   <= 1'b0;
      r_word_sent <= 1'b0;
      r_sync_sent <= 1'b0;
      r_beat      <= '0;
      r_shift     <= '0;
      r_wcnt      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_tx_in     <= w_tx_nxt;
      r_link_up   <= w_link_nxt;
      r_word_sent <= w_word_sent_nxt;
      r_sync_sent <= w_sync_sent_nxt;
      r_beat      <= w_beat_nxt;
      r_shift     <= w_shift_nxt;
      r_wcnt      <= w_wcnt_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lvds_tx_framer.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : tb_lvds_tx_framer
// Description : Self-checking bench for lvds_tx_framer. A queue-based model of
//               the transmit stream checks the main instance every cycle; a
//               second 48/16-bit instance gets directed checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lvds_tx_framer;

  localparam int SI = 4;
  localparam logic [31:0] IDLE = 32'h5252_5252;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        locked = 1'b0;
  logic        align = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  tx_in;
  logic        link_up;
  logic [3:0]  fifo_count;
  logic        word_sent;
  logic        sync_sent;

  logic        rst6 = 1'b1;
  logic        lk6 = 1'b0;
  logic        al6 = 1'b0;
  logic [47:0] sd6 = '0;
  logic        sv6 = 1'b0;
  logic        sr6;
  logic [15:0] tx6;
  logic        link6;
  logic [3:0]  cnt6;
  logic        ws6;
  logic        ss6;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  lvds_tx_framer #(.SYNC_INTERVAL(SI)) dut (
    .tx_inclock(clk), .pll_areset(rst), .tx_locked(locked), .tx_align_done(align),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .tx_in(tx_in),
    .link_up(link_up), .fifo_count(fifo_count), .word_sent(word_sent), .sync_sent(sync_sent)
  );

  lvds_tx_framer #(
    .BEAT_W(16), .WORD_W(48), .IDLE_WORD(48'h5252_5252_5252), .SYNC_INTERVAL(64)
  ) dut6 (
    .tx_inclock(clk), .pll_areset(rst6), .tx_locked(lk6), .tx_align_done(al6),
    .s_data(sd6), .s_valid(sv6), .s_ready(sr6), .tx_in(tx6),
    .link_up(link6), .fifo_count(cnt6), .word_sent(ws6), .sync_sent(ss6)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Model: the output stream as a queue of pending beats fed at word boundaries.
  // phase: 0 lock-wait, 1 training, 2 ack sent, 3 sync sent, 4 data.
  // --------------------------------------------------------------------------
  logic [31:0] m_fifo[$];
  logic [7:0]  m_beats[$];
  int          m_phase = 0;
  int          m_words = 0;
  logic [7:0]  m_tx = '0;
  bit          m_link = 0;
  bit          m_ws = 0;
  bit          m_ss = 0;

  always @(posedge clk or posedge rst) begin : model
    logic [31:0] w;
    bit          enq;
    if (rst) begin
      m_fifo.delete(); m_beats.delete();
      m_phase = 0; m_words = 0; m_tx = '0; m_link = 0; m_ws = 0; m_ss = 0;
    end else begin
      enq  = s_valid && locked && (m_fifo.size() < 8);
      m_ws = 0;
      m_ss = 0;
      if (!locked) begin
        m_phase = 0; m_tx = '0; m_words = 0;
        m_fifo.delete(); m_beats.delete();
      end else begin
        case (m_phase)
          0: begin m_phase = 1; m_tx = 8'h6A; end
          1: begin
            if (align) begin m_phase = 2; m_tx = 8'hA5; end
            else m_tx = 8'h6A;
          end
          2: begin m_phase = 3; m_tx = 8'h77; m_ss = 1; m_words = 0; end
          default: begin
            m_phase = 4;
            if (m_beats.size() == 0) begin
              if (m_words == SI) begin
                m_tx = 8'h77; m_ss = 1; m_words = 0;
              end else begin
                if (m_fifo.size() > 0) begin w = m_fifo.pop_front(); m_ws = 1; end
                else w = IDLE;
                for (int i = 3; i >= 0; i--) m_beats.push_back(w[i*8 +: 8]);
                m_words++;
                m_tx = m_beats.pop_front();
              end
            end else begin
              m_tx = m_beats.pop_front();
            end
          end
        endcase
        if (enq) m_fifo.push_back(s_data);
      end
      m_link = (m_phase == 4);
    end
  end

  // Compare the main instance against the model on every cycle out of reset.
  always @(negedge clk) begin
    if (!rst) begin
      check("tx_in",      {56'd0, tx_in},      {56'd0, m_tx});
      check("link_up",    {63'd0, link_up},    {63'd0, m_link});
      check("word_sent",  {63'd0, word_sent},  {63'd0, m_ws});
      check("sync_sent",  {63'd0, sync_sent},  {63'd0, m_ss});
      check("fifo_count", {60'd0, fifo_count}, 64'(m_fifo.size()));
      check("s_ready",    {63'd0, s_ready},    {63'd0, (locked && m_fifo.size() < 8)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench just before the edge that ends the current word, so a
  // word pushed now is enqueued there and started at the following boundary.
  task automatic wait_pre_boundary();
    bit found = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_beats.size() == 1 && m_words != SI) begin found = 1; break; end
      tick();
    end
    check("boundary_wait", {63'd0, found}, 64'd1);
  endtask

  task automatic wait_ws6(output bit found);
    found = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ws6) begin found = 1; break; end
    end
    check("ws6_wait", {63'd0, found}, 64'd1);
  endtask

  initial begin : stim
    int n_sync;
    int n_idle;
    bit ok;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_in",  {56'd0, tx_in}, 64'h0);
    check("rst_link",   {63'd0, link_up}, 64'h0);
    check("rst_count",  {60'd0, fifo_count}, 64'h0);
    check("rst_ws",     {63'd0, word_sent}, 64'h0);
    check("rst_ss",     {63'd0, sync_sent}, 64'h0);
    rst = 1'b0;

    // 1: bring-up sequence
    repeat (4) tick();
    check("t1_lockwait", {56'd0, tx_in}, 64'h00);
    locked = 1'b1;
    tick();
    check("t1_train0", {56'd0, tx_in}, 64'h6A);
    repeat (6) tick();
    check("t1_train6", {56'd0, tx_in}, 64'h6A);
    align = 1'b1;
    tick();
    check("t1_ack", {56'd0, tx_in}, 64'hA5);
    check("t1_ack_link", {63'd0, link_up}, 64'h0);
    align = 1'b0;
    tick();
    check("t1_sync", {56'd0, tx_in}, 64'h77);
    check("t1_sync_pulse", {63'd0, sync_sent}, 64'h1);
    check("t1_sync_link", {63'd0, link_up}, 64'h0);
    tick();
    check("t1_idle", {56'd0, tx_in}, 64'h52);
    check("t1_link", {63'd0, link_up}, 64'h1);
    check("t1_idle_ws", {63'd0, word_sent}, 64'h0);

    // 2: single word into an empty FIFO just before a boundary
    wait_pre_boundary();
    s_valid = 1'b1; s_data = 32'h81C3_E7FF;
    tick();
    s_valid = 1'b0;
    check("t2_count1", {60'd0, fifo_count}, 64'd1);
    tick();
    check("t2_b0", {56'd0, tx_in}, 64'h81);
    check("t2_ws", {63'd0, word_sent}, 64'h1);
    tick();
    check("t2_b1", {56'd0, tx_in}, 64'hC3);
    check("t2_ws_low", {63'd0, word_sent}, 64'h0);
    tick();
    check("t2_b2", {56'd0, tx_in}, 64'hE7);
    tick();
    check("t2_b3", {56'd0, tx_in}, 64'hFF);

    // 5: lock loss mid-word with words queued, then relock
    wait_pre_boundary();
    s_valid = 1'b1; s_data = 32'h81C3_E7FF;
    tick();
    s_data = 32'h8111_1111;
    tick();
    check("t5_b0", {56'd0, tx_in}, 64'h81);
    s_data = 32'h8222_2222;
    tick();
    check("t5_b1", {56'd0, tx_in}, 64'hC3);
    check("t5_count2", {60'd0, fifo_count}, 64'd2);
    locked = 1'b0;
    tick();
    check("t5_tx0", {56'd0, tx_in}, 64'h00);
    check("t5_flush", {60'd0, fifo_count}, 64'd0);
    check("t5_link0", {63'd0, link_up}, 64'h0);
    check("t5_ready0", {63'd0, s_ready}, 64'h0);
    repeat (3) tick();
    s_valid = 1'b0;
    check("t5_still_empty", {60'd0, fifo_count}, 64'd0);
    locked = 1'b1;
    tick();
    check("t5_retrain", {56'd0, tx_in}, 64'h6A);

    // 3: fill the FIFO while training, then drain in order
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1; s_data = 32'h90A0_B0C0 + 32'(i);
      tick();
    end
    s_data = 32'h90A0_B0C8;
    check("t3_full_ready", {63'd0, s_ready}, 64'h0);
    check("t3_full_count", {60'd0, fifo_count}, 64'd8);
    repeat (2) tick();
    check("t3_hold_count", {60'd0, fifo_count}, 64'd8);
    s_valid = 1'b0;
    align = 1'b1;
    tick();
    check("t3_ack", {56'd0, tx_in}, 64'hA5);
    align = 1'b0;
    tick();
    check("t3_sync", {56'd0, tx_in}, 64'h77);
    tick();
    check("t3_first", {56'd0, tx_in}, 64'h90);
    check("t3_first_ws", {63'd0, word_sent}, 64'h1);
    repeat (40) tick();
    check("t3_drained", {60'd0, fifo_count}, 64'd0);

    // 4: idle fill with re-sync every SI words
    n_sync = 0; n_idle = 0;
    for (int i = 0; i < 34; i++) begin
      tick();
      if (sync_sent) n_sync++;
      if (tx_in == 8'h52) n_idle++;
    end
    check("t4_sync_pulses", 64'(n_sync), 64'd2);
    check("t4_idle_beats", 64'(n_idle), 64'd32);

    // 6: 48-bit word on a 16-bit beat bus, then async reset mid-word
    rst6 = 1'b0; lk6 = 1'b1;
    repeat (2) tick();
    check("t6_train", {48'd0, tx6}, 64'h006A);
    al6 = 1'b1;
    tick();
    check("t6_ack", {48'd0, tx6}, 64'h00A5);
    al6 = 1'b0;
    repeat (2) tick();
    check("t6_idle", {48'd0, tx6}, 64'h5252);
    sv6 = 1'b1; sd6 = 48'h8001_2345_6789;
    tick();
    sv6 = 1'b0;
    wait_ws6(ok);
    if (ok) begin
      check("t6_b0", {48'd0, tx6}, 64'h8001);
      tick();
      check("t6_b1", {48'd0, tx6}, 64'h2345);
      tick();
      check("t6_b2", {48'd0, tx6}, 64'h6789);
    end
    sv6 = 1'b1; sd6 = 48'h8ABC_DEF0_1234;
    tick();
    sd6 = 48'h8111_2222_3333;
    tick();
    sv6 = 1'b0;
    wait_ws6(ok);
    if (ok) begin
      check("t6_a0", {48'd0, tx6}, 64'h8ABC);
      check("t6_cnt1", {60'd0, cnt6}, 64'd1);
      #2 rst6 = 1'b1;
      #1;
      check("t6_rst_tx", {48'd0, tx6}, 64'h0);
      check("t6_rst_link", {63'd0, link6}, 64'h0);
      check("t6_rst_ws", {63'd0, ws6}, 64'h0);
      check("t6_rst_ss", {63'd0, ss6}, 64'h0);
      check("t6_rst_cnt", {60'd0, cnt6}, 64'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
